// File: rtl/cnn_stream_pkg.sv
// Shared types and constants for the CNN DMA stream controller.
// The length check is enabled by defining CNN_STREAM_CTRL_LEN_CHECK_EN.
package cnn_stream_pkg;
    localparam int AXI_LEN_W = 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wstate_e;
endpackage

// File: rtl/cnn_ar_fifo.sv
// Read-request queue holding {arid, arlen}; push is ignored when full,
// even if a pop happens on the same edge.
module cnn_ar_fifo
    import cnn_stream_pkg::*;
#(
    parameter int ID_W     = 16,
    parameter int AR_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic [ID_W-1:0]      push_id,
    input  logic [AXI_LEN_W-1:0] push_len,
    input  logic                 pop,
    output logic                 full,
    output logic                 empty,
    output logic [ID_W-1:0]      head_id,
    output logic [AXI_LEN_W-1:0] head_len
);
    localparam int PTR_W = $clog2(AR_DEPTH);

    logic [ID_W-1:0]      id_mem  [AR_DEPTH];
    logic [AXI_LEN_W-1:0] len_mem [AR_DEPTH];
    logic [PTR_W:0]       wr_ptr, rd_ptr;
    logic                 do_push, do_pop;

    // Extra MSB on the pointers distinguishes full from empty.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            id_mem[wr_ptr[PTR_W-1:0]]  <= push_id;
            len_mem[wr_ptr[PTR_W-1:0]] <= push_len;
        end
    end

    assign head_id  = id_mem[rd_ptr[PTR_W-1:0]];
    assign head_len = len_mem[rd_ptr[PTR_W-1:0]];
endmodule

// File: rtl/cnn_dma_stream_ctrl.sv
// AXI control-path adapter between an AXI slave port and the CNN width
// converters. Define CNN_STREAM_CTRL_LEN_CHECK_EN to enable the W length check.
module cnn_dma_stream_ctrl
    import cnn_stream_pkg::*;
#(
    parameter int ID_W     = 16,
    parameter int AR_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_awvalid,
    output logic                 s_awready,
    input  logic [ID_W-1:0]      s_awid,
    input  logic [AXI_LEN_W-1:0] s_awlen,
    input  logic                 s_wvalid,
    output logic                 s_wready,
    input  logic                 s_wlast,
    output logic                 s_bvalid,
    input  logic                 s_bready,
    output logic [ID_W-1:0]      s_bid,
    output logic [1:0]           s_bresp,
    input  logic                 s_arvalid,
    output logic                 s_arready,
    input  logic [ID_W-1:0]      s_arid,
    input  logic [AXI_LEN_W-1:0] s_arlen,
    output logic                 s_rvalid,
    input  logic                 s_rready,
    output logic [ID_W-1:0]      s_rid,
    output logic                 s_rlast,
    output logic [1:0]           s_rresp,
    output logic                 str_in_valid,
    input  logic                 str_in_ready,
    input  logic                 str_out_valid,
    output logic                 str_out_ready,
    output logic                 err_sticky
);
    wstate_e              w_state, w_next;
    logic [ID_W-1:0]      aw_id;
    logic [AXI_LEN_W-1:0] aw_len, beat_cnt;
    logic                 aw_hs, w_hs;

    assign aw_hs = s_awvalid & (w_state == W_IDLE);
    assign w_hs  = s_wvalid & str_in_ready & (w_state == W_DATA);
    assign s_bid = aw_id;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state  <= W_IDLE;
            aw_id    <= '0;
            aw_len   <= '0;
            beat_cnt <= '0;
        end else begin
            w_state <= w_next;
            if (aw_hs) begin
                aw_id    <= s_awid;
                aw_len   <= s_awlen;
                beat_cnt <= '0;
            end else if (w_hs) begin
                beat_cnt <= beat_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_next       = w_state;
        s_awready    = 1'b0;
        s_wready     = 1'b0;
        str_in_valid = 1'b0;
        s_bvalid     = 1'b0;
        case (w_state)
            W_IDLE: begin
                s_awready = 1'b1;
                if (s_awvalid) w_next = W_DATA;
            end
            W_DATA: begin
                str_in_valid = s_wvalid;
                s_wready     = str_in_ready;
                if (w_hs && s_wlast) w_next = W_RESP;
            end
            W_RESP: begin
                s_bvalid = 1'b1;
                if (s_bready) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

`ifdef CNN_STREAM_CTRL_LEN_CHECK_EN
    logic len_err, burst_err, err_q;

    // Early wlast, or the final expected beat arriving without wlast.
    assign len_err = w_hs && (s_wlast ? (beat_cnt != aw_len) : (beat_cnt == aw_len));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            burst_err <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            if (aw_hs)        burst_err <= 1'b0;
            else if (len_err) burst_err <= 1'b1;
            if (len_err)      err_q     <= 1'b1;
        end
    end

    assign s_bresp    = burst_err ? RESP_SLVERR : RESP_OKAY;
    assign err_sticky = err_q;
`else
    logic unused_len;
    assign unused_len = ^{aw_len, beat_cnt};
    assign s_bresp    = RESP_OKAY;
    assign err_sticky = 1'b0;
`endif

    // Read side: queued AR requests meter the 64-to-512 result stream.
    logic                 ar_full, ar_empty, r_hs;
    logic [ID_W-1:0]      head_id;
    logic [AXI_LEN_W-1:0] head_len, rd_cnt;

    cnn_ar_fifo #(.ID_W(ID_W), .AR_DEPTH(AR_DEPTH)) u_ar_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (s_arvalid),
        .push_id  (s_arid),
        .push_len (s_arlen),
        .pop      (r_hs & s_rlast),
        .full     (ar_full),
        .empty    (ar_empty),
        .head_id  (head_id),
        .head_len (head_len)
    );

    assign s_arready     = ~ar_full;
    assign s_rvalid      = ~ar_empty & str_out_valid;
    assign str_out_ready = ~ar_empty & s_rready;
    assign s_rid         = head_id;
    assign s_rresp       = RESP_OKAY;
    assign s_rlast       = (rd_cnt == head_len);
    assign r_hs          = s_rvalid & s_rready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                rd_cnt <= '0;
        else if (r_hs && s_rlast) rd_cnt <= '0;
        else if (r_hs)          rd_cnt <= rd_cnt + 1'b1;
    end
endmodule

// File: tb/tb_cnn_dma_stream_ctrl.sv
// Self-checking bench: directed scenarios plus random traffic against a
// queue-based transaction model of the write and read control paths.
module tb_cnn_dma_stream_ctrl;
    import cnn_stream_pkg::*;

    localparam int ID_W  = 16;
    localparam int DEPTH = 4;

    logic            clk = 1'b0, rst = 1'b1;
    logic            s_awvalid = 0, s_awready, s_wvalid = 0, s_wready, s_wlast = 0;
    logic            s_bvalid, s_bready = 0, s_arvalid = 0, s_arready;
    logic            s_rvalid, s_rready = 0, s_rlast;
    logic            str_in_valid, str_in_ready = 0, str_out_valid = 0, str_out_ready;
    logic            err_sticky;
    logic [ID_W-1:0] s_awid = '0, s_bid, s_arid = '0, s_rid;
    logic [7:0]      s_awlen = '0, s_arlen = '0;
    logic [1:0]      s_bresp, s_rresp;

    cnn_dma_stream_ctrl #(.ID_W(ID_W), .AR_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awid(s_awid), .s_awlen(s_awlen),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wlast(s_wlast),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bid(s_bid), .s_bresp(s_bresp),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_arid(s_arid), .s_arlen(s_arlen),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rid(s_rid), .s_rlast(s_rlast),
        .s_rresp(s_rresp),
        .str_in_valid(str_in_valid), .str_in_ready(str_in_ready),
        .str_out_valid(str_out_valid), .str_out_ready(str_out_ready),
        .err_sticky(err_sticky)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Transaction-level model
    typedef struct packed { logic [ID_W-1:0] id; logic [7:0] len; } ar_t;
    ar_t             q[$];
    int              m_rcnt;
    bit              m_wbusy, m_resp, m_bad, m_err;
    logic [ID_W-1:0] m_bid;
    int              m_beat, m_len;
    int              d_str_in = 0, d_r = 0, d_rlast = 0, d_ar = 0;

    task automatic model_reset();
        m_wbusy = 0; m_resp = 0; m_bad = 0; m_err = 0;
        m_beat = 0; m_len = 0; m_rcnt = 0;
        q.delete();
    endtask

    // Called at a negedge with inputs already set; returns at the next negedge.
    task automatic step();
        bit aw, w, b, ar, r, rl;
        #1;
        if (rst) model_reset();
        chk("awready", 32'(s_awready), 32'(!m_wbusy && !m_resp));
        chk("wready", 32'(s_wready), 32'(m_wbusy && str_in_ready));
        chk("str_in_valid", 32'(str_in_valid), 32'(m_wbusy && s_wvalid));
        chk("bvalid", 32'(s_bvalid), 32'(m_resp));
        if (m_resp) begin
            chk("bid", 32'(s_bid), 32'(m_bid));
`ifdef CNN_STREAM_CTRL_LEN_CHECK_EN
            chk("bresp", 32'(s_bresp), m_bad ? 32'd2 : 32'd0);
`else
            chk("bresp", 32'(s_bresp), 32'd0);
`endif
        end
        chk("err_sticky", 32'(err_sticky), 32'(m_err));
        chk("arready", 32'(s_arready), 32'(q.size() < DEPTH));
        chk("rvalid", 32'(s_rvalid), 32'(q.size() > 0 && str_out_valid));
        chk("str_out_ready", 32'(str_out_ready), 32'(q.size() > 0 && s_rready));
        if (q.size() > 0) begin
            chk("rid", 32'(s_rid), 32'(q[0].id));
            chk("rlast", 32'(s_rlast), 32'(m_rcnt == int'(q[0].len)));
            chk("rresp", 32'(s_rresp), 32'd0);
        end
        if (str_in_valid && str_in_ready) d_str_in++;
        if (s_rvalid && s_rready) begin d_r++; if (s_rlast) d_rlast++; end
        if (s_arvalid && s_arready) d_ar++;
        aw = !rst && !m_wbusy && !m_resp && s_awvalid;
        w  = !rst && m_wbusy && s_wvalid && str_in_ready;
        b  = !rst && m_resp && s_bready;
        ar = !rst && s_arvalid && q.size() < DEPTH;
        r  = !rst && q.size() > 0 && str_out_valid && s_rready;
        rl = r && (m_rcnt == int'(q[0].len));
        @(posedge clk);
        if (aw) begin
            m_wbusy = 1; m_bid = s_awid; m_len = int'(s_awlen); m_beat = 0; m_bad = 0;
        end
        if (w) begin
`ifdef CNN_STREAM_CTRL_LEN_CHECK_EN
            if (s_wlast ? (m_beat != m_len) : (m_beat == m_len)) begin m_bad = 1; m_err = 1; end
`endif
            m_beat++;
            if (s_wlast) begin m_wbusy = 0; m_resp = 1; end
        end
        if (b) m_resp = 0;
        if (r) begin
            if (rl) begin void'(q.pop_front()); m_rcnt = 0; end
            else m_rcnt++;
        end
        if (ar) q.push_back('{id: s_arid, len: s_arlen});
        @(negedge clk);
    endtask

    initial begin
        int base, acc;
        model_reset();
        @(negedge clk);
        step(); step();
        rst = 1'b0;
        #1;
        chk("reset_awready", 32'(s_awready), 32'd1);
        chk("reset_bvalid", 32'(s_bvalid), 32'd0);
        chk("reset_rvalid", 32'(s_rvalid), 32'd0);
        chk("reset_err", 32'(err_sticky), 32'd0);
        @(negedge clk);

        // 8-beat write, id 5
        s_awvalid = 1; s_awid = 16'd5; s_awlen = 8'd7; step();
        s_awvalid = 0; str_in_ready = 1; s_wvalid = 1;
        base = d_str_in;
        for (int i = 0; i < 8; i++) begin s_wlast = (i == 7); step(); end
        s_wvalid = 0; s_wlast = 0;
        #1;
        chk("wr8_beats", 32'(d_str_in - base), 32'd8);
        chk("wr8_bvalid", 32'(s_bvalid), 32'd1);
        chk("wr8_bid", 32'(s_bid), 32'd5);
        chk("wr8_bresp", 32'(s_bresp), 32'd0);
        s_bready = 1; step(); s_bready = 0;

        // 8-beat read, id 3
        s_arvalid = 1; s_arid = 16'd3; s_arlen = 8'd7; step();
        s_arvalid = 0; str_out_valid = 1; s_rready = 1;
        base = d_r; acc = d_rlast;
        for (int i = 0; i < 8; i++) step();
        chk("rd8_beats", 32'(d_r - base), 32'd8);
        chk("rd8_rlast", 32'(d_rlast - acc), 32'd1);
        #1 chk("rd8_empty_rvalid", 32'(s_rvalid), 32'd0);
        @(negedge clk);

        // Stream valid with no AR pending must stall
        base = d_r;
        for (int i = 0; i < 20; i++) step();
        chk("stall_beats", 32'(d_r - base), 32'd0);
        s_arvalid = 1; s_arid = 16'd9; s_arlen = 8'd1; step();
        s_arvalid = 0; step(); step();
        chk("stall_release", 32'(d_r - base), 32'd2);
        str_out_valid = 0; s_rready = 0;

        // Five back-to-back ARs into a depth-4 queue
        base = d_ar;
        s_arvalid = 1; s_arlen = 8'd0;
        for (int i = 0; i < 5; i++) begin s_arid = 16'(10 + i); step(); end
        chk("ar_accepted", 32'(d_ar - base), 32'd4);
        #1 chk("ar_full_arready", 32'(s_arready), 32'd0);
        @(negedge clk);
        str_out_valid = 1; s_rready = 1;
        step();
        step();
        s_arvalid = 0;
        for (int i = 0; i < 6; i++) step();
        chk("ar_fifth_taken", 32'(d_ar - base), 32'd5);
        str_out_valid = 0; s_rready = 0;

`ifdef CNN_STREAM_CTRL_LEN_CHECK_EN
        // Short burst: awlen 3 but wlast on the third beat
        s_awvalid = 1; s_awid = 16'd6; s_awlen = 8'd3; step();
        s_awvalid = 0; s_wvalid = 1;
        for (int i = 0; i < 3; i++) begin s_wlast = (i == 2); step(); end
        s_wvalid = 0; s_wlast = 0;
        #1;
        chk("len_bresp", 32'(s_bresp), 32'd2);
        chk("len_err", 32'(err_sticky), 32'd1);
        s_bready = 1; step(); s_bready = 0;
        for (int i = 0; i < 3; i++) step();
        chk("len_err_held", 32'(err_sticky), 32'd1);
`endif

        // Reset in the middle of a write burst
        s_awvalid = 1; s_awid = 16'd7; s_awlen = 8'd7; step();
        s_awvalid = 0; s_wvalid = 1;
        for (int i = 0; i < 3; i++) step();
        rst = 1;
        #1;
        chk("midrst_bvalid", 32'(s_bvalid), 32'd0);
        chk("midrst_awready", 32'(s_awready), 32'd1);
        @(negedge clk);
        step(); step();
        rst = 0; s_wvalid = 0; s_bready = 1;
        for (int i = 0; i < 5; i++) step();
        chk("midrst_awready_after", 32'(s_awready), 32'd1);
        s_bready = 0;

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            rst           = ($urandom % 600 == 0);
            s_awvalid     = ($urandom % 3 == 0);
            s_awid        = 16'($urandom);
            s_awlen       = 8'($urandom_range(0, 7));
            s_wvalid      = ($urandom % 4 != 0);
            s_wlast       = (m_wbusy && m_beat == m_len) || ($urandom % 16 == 0);
            str_in_ready  = ($urandom % 3 != 0);
            s_bready      = ($urandom % 2 == 0);
            s_arvalid     = ($urandom % 3 == 0);
            s_arid        = 16'($urandom);
            s_arlen       = 8'($urandom_range(0, 3));
            str_out_valid = ($urandom % 3 != 0);
            s_rready      = ($urandom % 4 != 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
